// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns a load/store into one req/gnt/rvalid
// transaction, stalls the pipeline until the response, and formats load data.
module mem_stage_lsu (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWEnM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        StallM,
   output logic [31:0] LoadDataM,
   output logic        LoadValidM,
   output logic        LsuFaultM
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic              r_we;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [BE_W-1:0]   r_be;

   logic              w_fault;
   logic              w_issue;
   logic [BE_W-1:0]   w_be_in;
   logic [XLEN-1:0]   w_wdata_in;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [XLEN-1:0]   w_load_fmt;

   // Alignment / encoding check on the incoming instruction
   always_comb begin
      w_fault = 1'b0;
      case (Funct3M)
         3'b000, 3'b100: w_fault = 1'b0;
         3'b001, 3'b101: w_fault = ALUResultM[0];
         3'b010:         w_fault = |ALUResultM[1:0];
         default:        w_fault = 1'b1;
      endcase
   end

   // Byte enables and lane-replicated store data from the incoming operands
   always_comb begin
      w_be_in    = {BE_W{1'b1}};
      w_wdata_in = '0;
      if (MemWEnM) begin
         case (Funct3M[1:0])
            2'b00: begin
               w_be_in    = 4'b0001 << ALUResultM[1:0];
               w_wdata_in = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
               w_be_in    = 4'b0011 << {ALUResultM[1], 1'b0};
               w_wdata_in = {2{WriteDataM[15:0]}};
            end
            default: begin
               w_be_in    = {BE_W{1'b1}};
               w_wdata_in = WriteDataM;
            end
         endcase
      end
   end

   // Lane select and extension of the returned word using the latched offset
   always_comb begin
      w_byte = dmem_rdata[7:0];
      case (r_off)
         2'd0: w_byte = dmem_rdata[7:0];
         2'd1: w_byte = dmem_rdata[15:8];
         2'd2: w_byte = dmem_rdata[23:16];
         2'd3: w_byte = dmem_rdata[31:24];
         default: w_byte = dmem_rdata[7:0];
      endcase
      w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load_fmt = {24'd0, w_byte};
         3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
         3'b101:  w_load_fmt = {16'd0, w_half};
         default: w_load_fmt = dmem_rdata;
      endcase
   end

   assign w_issue = (r_state == S_IDLE) && MemReqM && !w_fault && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_funct3 <= '0;
         r_off    <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_be     <= '0;
      end else begin
         r_state <= w_next;
         if (w_issue) begin
            r_funct3 <= Funct3M;
            r_off    <= ALUResultM[1:0];
            r_we     <= MemWEnM;
            r_addr   <= {ALUResultM[31:2], 2'b00};
            r_wdata  <= w_wdata_in;
            r_be     <= w_be_in;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_be    = '0;
      StallM     = 1'b0;
      LoadDataM  = '0;
      LoadValidM = 1'b0;
      LsuFaultM  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (MemReqM) begin
               if (w_fault) begin
                  LsuFaultM = 1'b1;
               end else begin
                  dmem_req   = 1'b1;
                  dmem_we    = MemWEnM;
                  dmem_addr  = {ALUResultM[31:2], 2'b00};
                  dmem_wdata = w_wdata_in;
                  dmem_be    = w_be_in;
                  StallM     = 1'b1;
                  w_next     = dmem_gnt ? S_WAIT : S_REQ;
               end
            end
         end
         S_REQ: begin
            dmem_req   = 1'b1;
            dmem_we    = r_we;
            dmem_addr  = r_addr;
            dmem_wdata = r_wdata;
            dmem_be    = r_be;
            StallM     = 1'b1;
            if (dmem_gnt) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (dmem_rvalid) begin
               w_next = S_IDLE;
               if (!r_we) begin
                  LoadValidM = 1'b1;
                  LoadDataM  = w_load_fmt;
               end
            end else begin
               StallM = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
      // Async reset must silence the combinational outputs immediately
      if (reset) begin
         dmem_req   = 1'b0;
         dmem_we    = 1'b0;
         dmem_addr  = '0;
         dmem_wdata = '0;
         dmem_be    = '0;
         StallM     = 1'b0;
         LoadDataM  = '0;
         LoadValidM = 1'b0;
         LsuFaultM  = 1'b0;
         w_next     = S_IDLE;
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;
   logic        clk = 1'b0;
   logic        reset;
   logic        MemReqM, MemWEnM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        StallM;
   logic [31:0] LoadDataM;
   logic        LoadValidM, LsuFaultM;

   int checks   = 0;
   int failures = 0;

   mem_stage_lsu dut (
      .clk(clk), .reset(reset),
      .MemReqM(MemReqM), .MemWEnM(MemWEnM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .StallM(StallM), .LoadDataM(LoadDataM), .LoadValidM(LoadValidM),
      .LsuFaultM(LsuFaultM)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      MemReqM = 0; MemWEnM = 0; Funct3M = 3'b000; ALUResultM = 0; WriteDataM = 0;
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      MemReqM = 1; Funct3M = 3'b010; ALUResultM = 32'h100;
      @(negedge clk);
      checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", dmem_req); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", StallM); end
      checks++; if (LoadValidM !== 1'b0) begin failures++; $display("FAIL rst_lvalid got=%0b exp=0", LoadValidM); end
      checks++; if (LsuFaultM !== 1'b0) begin failures++; $display("FAIL rst_fault got=%0b exp=0", LsuFaultM); end
      checks++; if (LoadDataM !== 32'h0) begin failures++; $display("FAIL rst_ldata got=%h exp=0", LoadDataM); end
      step();
      reset = 1'b0;
      idle_inputs();
      step();
   endtask

   task automatic test_lw();
      int stalls = 0;
      MemReqM = 1; MemWEnM = 0; Funct3M = 3'b010; ALUResultM = 32'h100; dmem_gnt = 1;
      @(negedge clk);
      stalls += int'(StallM);
      checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL lw_req got=%0b exp=1", dmem_req); end
      checks++; if (dmem_addr !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=00000100", dmem_addr); end
      checks++; if (dmem_be !== 4'b1111) begin failures++; $display("FAIL lw_be got=%b exp=1111", dmem_be); end
      checks++; if (dmem_we !== 1'b0) begin failures++; $display("FAIL lw_we got=%0b exp=0", dmem_we); end
      step();
      dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      stalls += int'(StallM);
      checks++; if (LoadValidM !== 1'b1) begin failures++; $display("FAIL lw_lvalid got=%0b exp=1", LoadValidM); end
      checks++; if (LoadDataM !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_ldata got=%h exp=deadbeef", LoadDataM); end
      checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL lw_wait_req got=%0b exp=0", dmem_req); end
      checks++; if (stalls != 1) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=1", stalls); end
      step();
      idle_inputs();
      @(negedge clk);
      checks++; if (LoadDataM !== 32'h0 || LoadValidM !== 1'b0) begin failures++; $display("FAIL lw_after got=%h/%0b exp=0/0", LoadDataM, LoadValidM); end
      step();
   endtask

   task automatic test_lb_lbu();
      logic [2:0]  f3  [2] = '{3'b000, 3'b100};
      logic [31:0] exp [2] = '{32'hFFFFFF80, 32'h00000080};
      for (int i = 0; i < 2; i++) begin
         MemReqM = 1; MemWEnM = 0; Funct3M = f3[i]; ALUResultM = 32'h203; dmem_gnt = 1;
         @(negedge clk);
         checks++; if (dmem_addr !== 32'h200) begin failures++; $display("FAIL lb_addr[%0d] got=%h exp=00000200", i, dmem_addr); end
         step();
         dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h80FF0000;
         @(negedge clk);
         checks++; if (LoadDataM !== exp[i]) begin failures++; $display("FAIL lb_data[%0d] got=%h exp=%h", i, LoadDataM, exp[i]); end
         step();
         idle_inputs();
      end
      step();
   endtask

   task automatic test_sh_delay();
      int stalls = 0;
      MemReqM = 1; MemWEnM = 1; Funct3M = 3'b001; ALUResultM = 32'h302; WriteDataM = 32'h1234ABCD;
      for (int i = 0; i < 4; i++) begin
         dmem_gnt = (i == 3);
         if (i > 0) begin
            WriteDataM = 32'h0F0F0F0F;
            ALUResultM = 32'h777;
         end
         @(negedge clk);
         stalls += int'(StallM);
         checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL sh_req[%0d] got=%0b exp=1", i, dmem_req); end
         checks++; if (dmem_be !== 4'b1100) begin failures++; $display("FAIL sh_be[%0d] got=%b exp=1100", i, dmem_be); end
         checks++; if (dmem_wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata[%0d] got=%h exp=abcdabcd", i, dmem_wdata); end
         checks++; if (dmem_addr !== 32'h300 || dmem_we !== 1'b1) begin failures++; $display("FAIL sh_addr_we[%0d] got=%h/%0b exp=00000300/1", i, dmem_addr, dmem_we); end
         step();
      end
      dmem_gnt = 0;
      @(negedge clk);
      stalls += int'(StallM);
      checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL sh_wait_req got=%0b exp=0", dmem_req); end
      step();
      dmem_rvalid = 1; dmem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      stalls += int'(StallM);
      checks++; if (LoadValidM !== 1'b0) begin failures++; $display("FAIL sh_lvalid got=%0b exp=0", LoadValidM); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL sh_done_stall got=%0b exp=0", StallM); end
      checks++; if (stalls != 5) begin failures++; $display("FAIL sh_stall_cycles got=%0d exp=5", stalls); end
      step();
      idle_inputs();
      step();
   endtask

   task automatic test_fault();
      logic [2:0]  f3 [2] = '{3'b010, 3'b011};
      logic [31:0] ad [2] = '{32'h101, 32'h100};
      for (int i = 0; i < 2; i++) begin
         MemReqM = 1; MemWEnM = 0; Funct3M = f3[i]; ALUResultM = ad[i]; dmem_gnt = 1;
         @(negedge clk);
         checks++; if (LsuFaultM !== 1'b1) begin failures++; $display("FAIL fault_flag[%0d] got=%0b exp=1", i, LsuFaultM); end
         checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL fault_req[%0d] got=%0b exp=0", i, dmem_req); end
         checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL fault_stall[%0d] got=%0b exp=0", i, StallM); end
         step();
         idle_inputs();
         @(negedge clk);
         checks++; if (LsuFaultM !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL fault_after[%0d] got=%0b/%0b exp=0/0", i, LsuFaultM, dmem_req); end
         step();
      end
   endtask

   task automatic test_reset_mid();
      MemReqM = 1; MemWEnM = 0; Funct3M = 3'b010; ALUResultM = 32'h100; dmem_gnt = 1;
      step();
      dmem_gnt = 0;
      @(negedge clk);
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL rm_wait_stall got=%0b exp=1", StallM); end
      step();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0 || LoadValidM !== 1'b0 || LsuFaultM !== 1'b0 || LoadDataM !== 32'h0)
         begin failures++; $display("FAIL rm_during got=req%0b stall%0b lv%0b flt%0b data%h exp=all0", dmem_req, StallM, LoadValidM, LsuFaultM, LoadDataM); end
      step();
      reset = 1'b0;
      MemReqM = 0; dmem_rvalid = 1; dmem_rdata = 32'h12345678;
      @(negedge clk);
      checks++; if (LoadValidM !== 1'b0 || LoadDataM !== 32'h0) begin failures++; $display("FAIL rm_late_rvalid got=%0b/%h exp=0/0", LoadValidM, LoadDataM); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL rm_late_stall got=%0b exp=0", StallM); end
      step();
      idle_inputs();
      step();
   endtask

   task automatic test_back_to_back();
      MemReqM = 1; MemWEnM = 0; Funct3M = 3'b010; ALUResultM = 32'h10; dmem_gnt = 1;
      @(negedge clk);
      checks++; if (dmem_req !== 1'b1 || StallM !== 1'b1) begin failures++; $display("FAIL b2b_lw_issue got=%0b/%0b exp=1/1", dmem_req, StallM); end
      step();
      dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      checks++; if (StallM !== 1'b0 || LoadValidM !== 1'b1) begin failures++; $display("FAIL b2b_lw_done got=%0b/%0b exp=0/1", StallM, LoadValidM); end
      checks++; if (LoadDataM !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_lw_data got=%h exp=cafef00d", LoadDataM); end
      checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL b2b_gap_req got=%0b exp=0", dmem_req); end
      step();
      MemWEnM = 1; Funct3M = 3'b010; ALUResultM = 32'h20; WriteDataM = 32'h55AA55AA;
      dmem_gnt = 1; dmem_rvalid = 0;
      @(negedge clk);
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || StallM !== 1'b1) begin failures++; $display("FAIL b2b_sw_issue got=%0b/%0b/%0b exp=1/1/1", dmem_req, dmem_we, StallM); end
      checks++; if (dmem_wdata !== 32'h55AA55AA || dmem_be !== 4'b1111) begin failures++; $display("FAIL b2b_sw_data got=%h/%b exp=55aa55aa/1111", dmem_wdata, dmem_be); end
      step();
      dmem_gnt = 0; dmem_rvalid = 1;
      @(negedge clk);
      checks++; if (StallM !== 1'b0 || LoadValidM !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL b2b_sw_done got=%0b/%0b/%0b exp=0/0/0", StallM, LoadValidM, dmem_req); end
      step();
      idle_inputs();
      @(negedge clk);
      checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0b/%0b exp=0/0", dmem_req, StallM); end
      step();
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sh_delay();
      test_fault();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the RV32I 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB control/data register. It converts a memory instruction into a single-outstanding req/gnt/rvalid transaction on the data-memory port. It stalls the pipeline until the response arrives, then delivers aligned, sign/zero-extended load data for writeback.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- MemReqM  in  1  MEM-stage instruction is a load or store
- MemWEnM  in  1  1 = store, 0 = load
- Funct3M  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store source (rs2)
- dmem_req  out  1  request valid
- dmem_we  out  1  write request
- dmem_addr  out  32  word address, `{ALUResultM[31:2],2'b00}`
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  response (load data or store ack)
- dmem_rdata  in  32  raw read word
- StallM  out  1  hold IF..MEM, bubble into WB
- LoadDataM  out  32  formatted load result, valid when LoadValidM
- LoadValidM  out  1  load completes this cycle
- LsuFaultM  out  1  misaligned address or illegal funct3; op not issued

## Operation
- States: IDLE, REQ (req asserted, awaiting gnt), WAIT (granted, awaiting rvalid).
- IDLE, MemReqM=1, no fault:
  - Assert dmem_req combinationally.
  - Latch funct3, addr[1:0], MemWEnM.
  - gnt=1 → WAIT; else → REQ.
- REQ: hold dmem_req, dmem_addr, dmem_we, dmem_be, dmem_wdata from the latched copies. gnt → WAIT.
- WAIT: dmem_req=0. rvalid → IDLE.
  - Load: LoadValidM=1 and LoadDataM = formatted dmem_rdata in the same cycle.
  - Store: completion only.
- StallM = 1 for an issued op in IDLE, REQ, and WAIT-without-rvalid. StallM = 0 in the rvalid cycle, so the MEM/WB register captures LoadDataM at that edge.
- Fault: LB/LBU never fault; LH/LHU/SH fault if addr[0]=1; LW/SW fault if addr[1:0]≠0; funct3 3/6/7 fault.
  - On fault: LsuFaultM=1 for one cycle, no request, StallM=0, state stays IDLE.
- Byte enables:
  - SB: `4'b0001<<addr[1:0]`
  - SH: `4'b0011<<{addr[1],1'b0}`
  - SW: `4'b1111`
  - Loads: `4'b1111`
- dmem_wdata:
  - SB: `{4{rs2[7:0]}}`
  - SH: `{2{rs2[15:0]}}`
  - SW: `rs2`
- Load format: select byte/halfword by the latched offset.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Exactly one outstanding transaction. rvalid in IDLE or REQ is ignored.
- LoadDataM = 0 whenever LoadValidM=0.

## Timing
- Reset (async) forces state=IDLE and clears the latched copies. While reset is high, dmem_req, StallM, LoadValidM, LsuFaultM = 0 and LoadDataM = 0.
- Minimum latency: gnt in the issue cycle, rvalid on the next cycle gives 1 stall cycle, 2 cycles total in MEM.
- Each cycle of gnt delay or rvalid delay adds one stall cycle.
- Reset mid-transaction abandons the op. A late rvalid after reset is ignored (state IDLE).
- While stalled, MemReqM, Funct3M, ALUResultM and WriteDataM are stable by pipeline contract. The block uses the latched copies regardless.
- After completion, the next MemReqM is evaluated in the following cycle. Back-to-back memory ops are legal.

## Test plan
- LW at 0x100, gnt in the issue cycle, rvalid+rdata=0xDEADBEEF one cycle later → StallM high for 1 cycle; LoadValidM=1 with LoadDataM=0xDEADBEEF; dmem_be=4'b1111.
- LB at 0x203 with rdata=0x80FF_0000 → LoadDataM=0xFFFFFF80. LBU at the same address → LoadDataM=0x00000080.
- SH at 0x302 with rs2=0x1234ABCD, gnt delayed 3 cycles then rvalid 2 cycles later → dmem_be=4'b1100 and dmem_wdata=0xABCDABCD held stable through REQ; StallM high for 5 cycles; LoadValidM stays 0.
- LW at 0x101 → LsuFaultM=1 for one cycle, dmem_req never asserted, StallM=0. The same holds for funct3=3'b011.
- Reset asserted during WAIT, then rvalid arrives after reset is released → all outputs 0 during reset, state IDLE, the rvalid produces no LoadValidM.
- Back-to-back LW then SW with zero gnt delay → two transactions; StallM deasserts exactly on each rvalid cycle; the second dmem_req rises on the cycle after the first completes.
